// File: rtl/gpio_input_port.sv
// gpio_input_port: memory-mapped GPIO input with 2-FF synchronizer, per-bit debounce, W1C rising-edge status and maskable irq
module gpio_input_port #(
    parameter int          WIDTH           = 32,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] ADDR_DATA       = 32'h0000ABD0,
    parameter logic [31:0] ADDR_EDGE       = 32'h0000ABD4,
    parameter logic [31:0] ADDR_IE         = 32'h0000ABD8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [31:0]      Address,
    input  logic             MemW,
    input  logic [31:0]      Wdata,
    output logic [31:0]      Rdata,
    output logic             hit,
    output logic             irq
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0]      r_sync1, r_sync2, r_stable, r_edge, r_ie;
    logic [WIDTH-1:0][7:0] r_cnt, w_cnt_next;
    logic [WIDTH-1:0]      w_stable_next, w_edge_next, w_ie_next, w_clr;
    logic                  w_sel_data, w_sel_edge, w_sel_ie, w_unused;
    logic                  r_irq;
    assign w_sel_data = Address[31:2] == ADDR_DATA[31:2];
    assign w_sel_edge = Address[31:2] == ADDR_EDGE[31:2];
    assign w_sel_ie   = Address[31:2] == ADDR_IE[31:2];
    assign hit        = w_sel_data | w_sel_edge | w_sel_ie;
    assign irq        = r_irq;
    assign w_unused   = &{1'b0, Address[1:0], Wdata};
    // per-bit debounce: count consecutive disagreeing samples, flip stable when the count completes
    always_comb begin
        w_stable_next = r_stable;
        w_cnt_next    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) w_stable_next[i] = ~r_stable[i];
                else w_cnt_next[i] = r_cnt[i] + 8'd1;
            end
        end
    end
    // next-state of status and mask; a rising edge beats a simultaneous clear
    always_comb begin
        w_clr       = (MemW && w_sel_edge) ? Wdata[WIDTH-1:0] : '0;
        w_edge_next = (r_edge & ~w_clr) | (w_stable_next & ~r_stable);
        w_ie_next   = (MemW && w_sel_ie) ? Wdata[WIDTH-1:0] : r_ie;
    end
    // read mux, zero-extended to the bus width
    always_comb begin
        Rdata = '0;
        Rdata[WIDTH-1:0] = w_sel_data ? r_stable : w_sel_edge ? r_edge : w_sel_ie ? r_ie : '0;
    end
    // state registers; irq is computed from next-state so it rises with the status bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_edge   <= '0;
            r_ie     <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1  <= pins_in;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_cnt    <= w_cnt_next;
            r_edge   <= w_edge_next;
            r_ie     <= w_ie_next;
            r_irq    <= |(w_edge_next & w_ie_next);
        end
    end
endmodule

// File: tb/tb_gpio_input_port.sv
// tb_gpio_input_port: directed and randomized checks of gpio_input_port against a cycle reference model
module tb_gpio_input_port;
    localparam int          DC = 4;
    localparam logic [31:0] A_DATA = 32'h0000ABD0;
    localparam logic [31:0] A_EDGE = 32'h0000ABD4;
    localparam logic [31:0] A_IE   = 32'h0000ABD8;
    logic        clk = 1'b0, rst = 1'b1, MemW = 1'b0;
    logic [31:0] pins_in = '0, Address = '0, Wdata = '0;
    logic [31:0] Rdata;
    logic        hit, irq;
    int          total = 0, bad = 0;
    logic [31:0] m_s1, m_s2, m_stable, m_est, m_ie;
    logic        m_irq;
    int          m_run [32];

    gpio_input_port #(.WIDTH(32), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .pins_in(pins_in), .Address(Address), .MemW(MemW),
        .Wdata(Wdata), .Rdata(Rdata), .hit(hit), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_reg(input logic [31:0] a, input logic [31:0] r);
        return a[31:2] == r[31:2];
    endfunction

    function automatic void m_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_est = '0; m_ie = '0; m_irq = 1'b0;
        for (int b = 0; b < 32; b++) m_run[b] = 0;
    endfunction

    // one clock edge of the reference: a pin level change is accepted only after DC straight disagreeing samples
    function automatic void m_step();
        logic [31:0] ns, clr;
        ns = m_stable;
        for (int b = 0; b < 32; b++) begin
            m_run[b] = (m_s2[b] != m_stable[b]) ? m_run[b] + 1 : 0;
            if (m_run[b] == DC) begin
                ns[b] = ~ns[b];
                m_run[b] = 0;
            end
        end
        clr = (MemW && is_reg(Address, A_EDGE)) ? Wdata : 32'h0;
        m_est = (m_est & ~clr) | (ns & ~m_stable);
        if (MemW && is_reg(Address, A_IE)) m_ie = Wdata;
        m_stable = ns;
        m_s2 = m_s1;
        m_s1 = pins_in;
        m_irq = |(m_est & m_ie);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) m_step();
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        MemW = 1'b0;
        Address = a;
        #1;
        chk(tag, Rdata, exp);
    endtask

    task automatic chk_all(input string tag);
        rd(A_DATA, m_stable, {tag, "_data"});
        rd(A_EDGE, m_est, {tag, "_edge"});
        rd(A_IE, m_ie, {tag, "_ie"});
        chk({tag, "_irq"}, 32'(irq), 32'(m_irq));
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
        Address = a;
        Wdata = d;
        MemW = 1'b1;
        #1;
        chk({tag, "_hit"}, 32'(hit), 32'h1);
        tick();
        MemW = 1'b0;
    endtask

    initial begin
        int hold;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        Address = 32'h00001000;
        #1;
        chk("miss_hit", 32'(hit), 32'h0);
        chk("miss_rdata", Rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        pins_in = 32'h1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            rd(A_DATA, (e < 5) ? 32'h0 : 32'h1, "lat_data");
        end
        rd(A_EDGE, 32'h1, "lat_edge");
        chk_all("lat");
        pins_in = 32'h9;
        repeat (3) tick();
        pins_in = 32'h1;
        repeat (8) tick();
        rd(A_DATA, 32'h1, "glitch_data");
        rd(A_EDGE, 32'h1, "glitch_edge");
        chk_all("glitch");
        pins_in = 32'h5;
        repeat (7) tick();
        rd(A_EDGE, 32'h5, "two_edges");
        chk("irq_masked", 32'(irq), 32'h0);
        store(A_IE, 32'h4, "ie_w");
        chk("irq_enabled", 32'(irq), 32'h1);
        rd(A_IE, 32'h4, "ie_rd");
        store(A_EDGE + 32'h2, 32'h4, "w1c");
        rd(A_EDGE, 32'h1, "w1c_edge");
        chk("irq_cleared", 32'(irq), 32'h0);
        store(A_IE + 32'h1, 32'h1, "ie_w1");
        chk("irq_bit0", 32'(irq), 32'h1);
        store(A_IE, 32'h0, "ie_w0");
        chk("irq_ie_mask", 32'(irq), 32'h0);
        store(A_DATA, 32'hFFFFFFFF, "data_w");
        chk_all("data_ignored");
        rd(A_DATA, 32'h5, "data_ro");
        Address = 32'h0000ABDC;
        #1;
        chk("miss2_hit", 32'(hit), 32'h0);
        chk("miss2_rdata", Rdata, 32'h0);
        store(A_EDGE, 32'h1, "pre_race");
        rd(A_EDGE, 32'h0, "pre_race_edge");
        pins_in = 32'h4;
        repeat (7) tick();
        rd(A_DATA, 32'h4, "race_low");
        pins_in = 32'h5;
        repeat (5) tick();
        rd(A_DATA, 32'h4, "race_before");
        store(A_EDGE, 32'h1, "race");
        rd(A_DATA, 32'h5, "race_data");
        rd(A_EDGE, 32'h1, "race_set_wins");
        chk_all("race");
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                pins_in = pins_in ^ (32'($urandom) & 32'hFF);
                hold = $urandom_range(1, 8);
            end
            hold--;
            Address = A_DATA + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
            MemW = ($urandom_range(0, 3) == 0);
            Wdata = $urandom;
            #1;
            chk("rnd_hit", 32'(hit), 32'(is_reg(Address, A_DATA) || is_reg(Address, A_EDGE) || is_reg(Address, A_IE)));
            tick();
            chk_all("rnd");
        end
        MemW = 1'b0;
        pins_in = 32'hFF;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk_all("async_rst");
        rd(A_DATA, 32'h0, "async_rst_data");
        chk("async_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            rd(A_DATA, (e < 5) ? 32'h0 : 32'hFF, "post_rst_data");
        end
        rd(A_EDGE, 32'hFF, "post_rst_edge");
        chk_all("post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
